// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state type and width helpers for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  // Bit counter only has to reach WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic bit width_ok(input int unsigned width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - combinational one-bit full adder cell
module fa_cell (
  input  logic i0,
  input  logic i1,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = i0 ^ i1 ^ cin;
  assign cout = (i0 & i1) | (cin & (i0 ^ i1));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial two's-complement adder, one bit per clock
// Optional subtract port enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned   CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("serial_adder: WIDTH must be in 2..32");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub_q;
  logic             r_c_msb;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_sub_in;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // Subtraction is A + ~B + 1: B is inverted bitwise and the carry is seeded with sub.
  fa_cell u_fa (
    .i0   (r_a_sr[0]),
    .i1   (r_b_sr[0] ^ r_sub_q),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_last = w_step && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sub_q  <= 1'b0;
      r_c_msb  <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_sum_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= w_sub_in;
      r_sub_q  <= w_sub_in;
    end else if (w_step) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= {w_fa_sum, r_sum_sr[WIDTH-1:1]};
      r_carry  <= w_fa_cout;
      r_cnt    <= r_cnt + CW'(1);
      // Carry out of bit WIDTH-2 is the carry into the MSB, needed for signed overflow.
      if (r_cnt == CNT_MSB_IN) begin
        r_c_msb <= w_fa_cout;
      end
      if (w_last) begin
        r_sum  <= {w_fa_sum, r_sum_sr[WIDTH-1:1]};
        r_cout <= w_fa_cout;
        r_ovf  <= r_c_msb ^ w_fa_cout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8, 2 and 32
module tb_serial_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, start2, start32;
  logic [7:0]  a8, b8;
  logic [1:0]  a2, b2;
  logic [31:0] a32, b32;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub8, sub2, sub32;
`endif
  logic        busy8, busy2, busy32;
  logic        done8, done2, done32;
  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [31:0] sum32;
  logic        cout8, cout2, cout32;
  logic        ovf8, ovf2, ovf32;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q32[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub32),
`endif
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic sel_done(input int w);
    case (w)
      8:       return done8;
      2:       return done2;
      default: return done32;
    endcase
  endfunction

  function automatic logic sel_busy(input int w);
    case (w)
      8:       return busy8;
      2:       return busy2;
      default: return busy32;
    endcase
  endfunction

  task automatic mon(input int w, input logic [31:0] s, input logic c, input logic o);
    exp_t e;
    int   depth;
    e = '0;
    case (w)
      8:       begin depth = q8.size();  if (depth > 0) e = q8.pop_front();  end
      2:       begin depth = q2.size();  if (depth > 0) e = q2.pop_front();  end
      default: begin depth = q32.size(); if (depth > 0) e = q32.pop_front(); end
    endcase
    check($sformatf("w%0d expected result pending at done", w), (depth > 0) ? 32'd1 : 32'd0, 32'd1);
    if (depth > 0) begin
      check($sformatf("w%0d sum", w), s, e.sum);
      check($sformatf("w%0d cout", w), {31'b0, c}, {31'b0, e.cout});
      check($sformatf("w%0d ovf", w), {31'b0, o}, {31'b0, e.ovf});
    end
  endtask

  always @(negedge clk) begin
    if (done8)  mon(8,  {24'b0, sum8}, cout8, ovf8);
    if (done2)  mon(2,  {30'b0, sum2}, cout2, ovf2);
    if (done32) mon(32, sum32, cout32, ovf32);
  end

  task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] es, input logic ec, input logic eo, input bit push);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo;
    @(negedge clk);
    case (w)
      8: begin
        a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = s;
`endif
        if (push) q8.push_back(e);
      end
      2: begin
        a2 = a[1:0]; b2 = b[1:0]; start2 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub2 = s;
`endif
        if (push) q2.push_back(e);
      end
      default: begin
        a32 = a; b32 = b; start32 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub32 = s;
`endif
        if (push) q32.push_back(e);
      end
    endcase
    @(negedge clk);
    start8 = 1'b0; start2 = 1'b0; start32 = 1'b0;
  endtask

  // Called on the first falling edge after the accepting edge.
  task automatic wait_done(input int w, output int lat, output int busy_cyc);
    bit got = 0;
    lat      = 0;
    busy_cyc = sel_busy(w) ? 1 : 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (sel_done(w)) got = 1;
      else if (sel_busy(w)) busy_cyc++;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL w%0d done timeout: no done within 40 cycles, required a done pulse", w);
    end
  endtask

  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] es, input logic ec, input logic eo);
    int lat, bc;
    issue(w, a, b, s, es, ec, eo, 1'b1);
    wait_done(w, lat, bc);
  endtask

  initial begin
    int lat, bc, t, ndone;
    int tdone[3];
    rst_n = 1'b0;
    start8 = 0; start2 = 0; start32 = 0;
    a8 = 0; b8 = 0; a2 = 0; b2 = 0; a32 = 0; b32 = 0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 0; sub2 = 0; sub32 = 0;
`endif
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy8}, 32'd0);
    check("reset done", {31'b0, done8}, 32'd0);
    check("reset sum",  {24'b0, sum8}, 32'd0);
    check("reset cout", {31'b0, cout8}, 32'd0);
    check("reset ovf",  {31'b0, ovf8}, 32'd0);
    rst_n = 1'b1;

    issue(8, 100, 27, 0, 127, 0, 0, 1'b1);
    wait_done(8, lat, bc);
    check("w8 done latency", lat, 32'd8);
    check("w8 busy cycles before done", bc, 32'd8);
    check("w8 busy at done", {31'b0, busy8}, 32'd1);
    @(negedge clk);
    check("w8 done is one cycle", {31'b0, done8}, 32'd0);
    check("w8 busy falls after done", {31'b0, busy8}, 32'd0);

    do_op(8, 100, 100, 0, 200, 0, 1);
    do_op(8, 200, 100, 0, 44,  1, 0);
    do_op(8, 255, 1,   0, 0,   1, 0);
    do_op(8, 127, 1,   0, 128, 0, 1);
    do_op(8, 128, 128, 0, 0,   1, 1);
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8, 5,    7, 1, 254,  0, 0);
    do_op(8, 8'h80, 1, 1, 8'h7F, 1, 1);
    do_op(8, 7,    5, 1, 2,    1, 0);
    do_op(8, 0,    0, 1, 0,    1, 0);
`endif

    // start during RUN cycle 3 with other operands must be dropped
    issue(8, 10, 20, 0, 30, 0, 0, 1'b1);
    @(negedge clk);
    a8 = 1; b8 = 1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(8, lat, bc);
    repeat (14) @(negedge clk);
    check("w8 idle after ignored start", {31'b0, busy8}, 32'd0);
    check("w8 sum held after ignored start", {24'b0, sum8}, 32'd30);

    // start held high: RUN x8, DONE, IDLE, accept -> one result every 10 cycles
    @(negedge clk);
    a8 = 3; b8 = 4; start8 = 1'b1;
    for (int i = 0; i < 3; i++) q8.push_back('{sum: 32'd7, cout: 1'b0, ovf: 1'b0});
    t = 0; ndone = 0;
    while (t < 60 && ndone < 3) begin
      @(negedge clk);
      t++;
      if (done8) begin
        tdone[ndone] = t;
        ndone++;
      end
    end
    start8 = 1'b0;
    check("w8 held-start done count", ndone, 32'd3);
    if (ndone == 3) begin
      check("w8 held-start interval 1", tdone[1] - tdone[0], 32'd10);
      check("w8 held-start interval 2", tdone[2] - tdone[1], 32'd10);
    end

    // reset in RUN cycle 4 aborts the op with no done
    issue(8, 50, 60, 0, 110, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'b0, busy8}, 32'd0);
    check("abort done", {31'b0, done8}, 32'd0);
    check("abort sum",  {24'b0, sum8}, 32'd0);
    check("abort cout", {31'b0, cout8}, 32'd0);
    check("abort ovf",  {31'b0, ovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_op(8, 50, 60, 0, 110, 0, 0);

    do_op(2, 1, 1, 0, 2, 0, 1);
    do_op(2, 3, 3, 0, 2, 1, 0);
    do_op(2, 2, 2, 0, 0, 1, 1);
    do_op(2, 2, 1, 0, 3, 0, 0);
    do_op(2, 3, 1, 0, 0, 1, 0);

    do_op(32, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 0);
    do_op(32, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, 1);
    do_op(32, 32'h1234_5678, 32'h1111_1111, 0, 32'h2345_6789, 0, 0);
    do_op(32, 32'h8000_0000, 32'h8000_0000, 0, 32'h0000_0000, 1, 1);
    do_op(32, 32'hDEAD_BEEF, 32'h2152_4111, 0, 32'h0000_0000, 1, 0);

    repeat (3) @(negedge clk);
    check("w8 scoreboard drained",  q8.size(),  32'd0);
    check("w2 scoreboard drained",  q2.size(),  32'd0);
    check("w32 scoreboard drained", q32.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
